// File: rtl/cpu_pkg.sv
// Shared types and default widths for the CPU RAM block.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int CPU_ADDR_W = 8;
  localparam int CPU_DATA_W = 8;

endpackage

// File: rtl/ram_array.sv
// Word storage: one synchronous write port, one asynchronous read port, no reset.
module ram_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_ram.sv
// CPU program/data RAM with MAR: loader init port during LOAD, CPU bus port in RUN,
// loaded-word counter and sticky protocol-error flag.
module cpu_ram
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              loading_ram,
  input  logic              init_set_addr,
  input  logic              init_set_ram,
  input  logic [ADDR_W-1:0] init_address,
  input  logic [DATA_W-1:0] init_data,
  input  logic              set_mar,
  input  logic              set_ram,
  input  logic              en_ram,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic [ADDR_W-1:0] mar,
  output logic              cpu_run,
  output logic [ADDR_W:0]   words_loaded,
  output logic              init_err
);

  localparam logic [ADDR_W:0] WORDS_MAX = (ADDR_W+1)'(DEPTH);

  // Assertion is immediate; release is held off for two clock edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic              run_q, run_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              err_q, err_d;
  logic              seen_q, seen_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              cpu_strobe;

  assign cpu_strobe = set_mar | set_ram | en_ram;

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    run_d   = run_q;
    words_d = words_q;
    err_d   = err_q;
    seen_d  = seen_q;
    we      = 1'b0;
    waddr   = mar_q;
    wdata   = bus_in;
    unique case (state_q)
      IDLE: begin
        if (cpu_strobe) err_d = 1'b1;
        if (loading_ram) begin
          state_d = LOAD;
          words_d = '0;
          run_d   = 1'b0;
          seen_d  = 1'b0;
        end
      end
      LOAD: begin
        if (cpu_strobe) err_d = 1'b1;
        if (init_set_addr) begin
          mar_d  = init_address;
          seen_d = 1'b1;
        end
        // A same-cycle address strobe steers the write around the MAR register.
        if (init_set_ram) begin
          we     = 1'b1;
          wdata  = init_data;
          waddr  = init_set_addr ? init_address : mar_q;
          seen_d = 1'b0;
          if (!init_set_addr && !seen_q) err_d = 1'b1;
          if (words_q != WORDS_MAX) words_d = words_q + 1'b1;
        end
        if (!loading_ram) begin
          state_d = RUN;
          run_d   = 1'b1;
        end
      end
      RUN: begin
        if (set_mar && set_ram) begin
          err_d = 1'b1;
        end else begin
          if (set_mar) mar_d = ADDR_W'(bus_in);
          if (set_ram) we = 1'b1;
        end
        if (loading_ram) begin
          state_d = LOAD;
          words_d = '0;
          run_d   = 1'b0;
          seen_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mar_q   <= '0;
      run_q   <= 1'b0;
      words_q <= '0;
      err_q   <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      run_q   <= run_d;
      words_q <= words_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
    end
  end

  ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (mar_q),
    .rdata_o (rdata)
  );

  assign bus_oe       = en_ram && (state_q == RUN);
  assign bus_out      = bus_oe ? rdata : '0;
  assign mar          = mar_q;
  assign cpu_run      = run_q;
  assign words_loaded = words_q;
  assign init_err     = err_q;

endmodule

// File: tb/tb_cpu_ram.sv
// Scoreboarded bench for cpu_ram: expected read data queued when a read is driven.
module tb_cpu_ram;

  logic       clk = 1'b0;
  logic       reset;
  logic       loading_ram, init_set_addr, init_set_ram;
  logic [7:0] init_address, init_data;
  logic       set_mar, set_ram, en_ram;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] mar;
  logic       cpu_run;
  logic [8:0] words_loaded;
  logic       init_err;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] m_mem [256];
  logic [7:0] m_mar;
  logic [7:0] sb_q [$];

  always #5 clk = ~clk;

  cpu_ram dut (
    .clk           (clk),
    .reset         (reset),
    .loading_ram   (loading_ram),
    .init_set_addr (init_set_addr),
    .init_set_ram  (init_set_ram),
    .init_address  (init_address),
    .init_data     (init_data),
    .set_mar       (set_mar),
    .set_ram       (set_ram),
    .en_ram        (en_ram),
    .bus_in        (bus_in),
    .bus_out       (bus_out),
    .bus_oe        (bus_oe),
    .mar           (mar),
    .cpu_run       (cpu_run),
    .words_loaded  (words_loaded),
    .init_err      (init_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    repeat (3) cyc();
    m_mar = 8'h00;
  endtask

  task automatic start_load();
    loading_ram = 1'b1;
    cyc();
  endtask

  task automatic init_wr(input logic [7:0] a, input logic [7:0] d);
    init_set_addr = 1'b1;
    init_address  = a;
    cyc();
    init_set_addr = 1'b0;
    init_set_ram  = 1'b1;
    init_data     = d;
    cyc();
    init_set_ram  = 1'b0;
    m_mem[a] = d;
    m_mar    = a;
  endtask

  task automatic cpu_setmar(input logic [7:0] a);
    set_mar = 1'b1;
    bus_in  = a;
    cyc();
    set_mar = 1'b0;
    m_mar   = a;
  endtask

  task automatic cpu_wr(input logic [7:0] d);
    set_ram = 1'b1;
    bus_in  = d;
    cyc();
    set_ram = 1'b0;
    m_mem[m_mar] = d;
  endtask

  task automatic cpu_rd(input string tag);
    logic [7:0] e;
    en_ram = 1'b1;
    sb_q.push_back(m_mem[m_mar]);
    #2;
    e = sb_q.pop_front();
    chk(tag, bus_out, e);
    chk({tag, "_oe"}, bus_oe, 1);
    en_ram = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mar"},   mar, 0);
    chk({tag, "_run"},   cpu_run, 0);
    chk({tag, "_words"}, words_loaded, 0);
    chk({tag, "_err"},   init_err, 0);
    chk({tag, "_oe"},    bus_oe, 0);
    chk({tag, "_bus"},   bus_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] e;
    reset = 1'b0;
    loading_ram = 0; init_set_addr = 0; init_set_ram = 0;
    init_address = 0; init_data = 0;
    set_mar = 0; set_ram = 0; en_ram = 0; bus_in = 0;
    m_mar = 0;
    repeat (3) cyc();
    chk_reset_outputs("por");
    reset = 1'b1;
    repeat (3) cyc();

    // Load three words and read one back
    start_load();
    init_wr(8'h00, 8'h1A);
    init_wr(8'h01, 8'h2B);
    init_wr(8'h02, 8'h3C);
    chk("words3", words_loaded, 3);
    chk("run_in_load", cpu_run, 0);
    loading_ram = 1'b0;
    cyc();
    chk("run_rise", cpu_run, 1);
    chk("words3_run", words_loaded, 3);
    chk("err_clean", init_err, 0);
    cpu_setmar(8'h01);
    chk("mar1", mar, 8'h01);
    cpu_rd("rd_2B");

    // CPU write, then write and read in the same cycle
    cpu_setmar(8'h80);
    cpu_wr(8'h55);
    cpu_rd("rd_55");
    set_ram = 1'b1;
    bus_in  = 8'h66;
    en_ram  = 1'b1;
    sb_q.push_back(m_mem[m_mar]);
    #2;
    e = sb_q.pop_front();
    chk("rd_prewrite", bus_out, e);
    cyc();
    set_ram = 1'b0;
    m_mem[m_mar] = 8'h66;
    cpu_rd("rd_66");
    chk("err_clean2", init_err, 0);

    // Reload, CPU write attempt during LOAD
    loading_ram = 1'b1;
    cyc();
    chk("reload_run", cpu_run, 0);
    chk("reload_words", words_loaded, 0);
    set_ram = 1'b1;
    bus_in  = 8'h99;
    cyc();
    set_ram = 1'b0;
    chk("err_cpu_in_load", init_err, 1);
    loading_ram = 1'b0;
    cyc();
    cpu_rd("rd_unchanged");

    // Reset while running with a read enabled
    en_ram = 1'b1;
    reset  = 1'b0;
    #1;
    chk_reset_outputs("rst_run");
    en_ram = 1'b0;
    cyc();
    reset = 1'b1;
    repeat (3) cyc();
    m_mar = 8'h00;

    // Two init writes without an address strobe in between
    start_load();
    init_set_addr = 1'b1;
    init_address  = 8'h40;
    cyc();
    init_set_addr = 1'b0;
    m_mar = 8'h40;
    init_set_ram = 1'b1;
    init_data    = 8'hAA;
    cyc();
    chk("err_first_ok", init_err, 0);
    init_data = 8'hBB;
    cyc();
    init_set_ram = 1'b0;
    m_mem[8'h40] = 8'hBB;
    chk("err_order", init_err, 1);
    chk("words2", words_loaded, 2);
    chk("mar40", mar, 8'h40);
    loading_ram = 1'b0;
    cyc();
    cpu_rd("rd_BB");

    // Reset after 5 of 10 writes, then empty load
    do_reset();
    start_load();
    for (int i = 0; i < 5; i++) init_wr(8'(8'h20 + i), 8'(8'hC0 + i));
    reset = 1'b0;
    #1;
    chk("midload_words", words_loaded, 0);
    chk("midload_run", cpu_run, 0);
    cyc();
    reset = 1'b1;
    repeat (3) cyc();
    m_mar = 8'h00;
    start_load();
    loading_ram = 1'b0;
    cyc();
    chk("empty_words", words_loaded, 0);
    chk("empty_run", cpu_run, 1);
    for (int i = 0; i < 5; i++) begin
      cpu_setmar(8'(8'h20 + i));
      cpu_rd("rd_kept");
    end

    // Both CPU write strobes together
    set_mar = 1'b1;
    set_ram = 1'b1;
    bus_in  = 8'h10;
    cyc();
    set_mar = 1'b0;
    set_ram = 1'b0;
    chk("both_mar", mar, 8'h24);
    chk("both_err", init_err, 1);
    cpu_rd("rd_both");

    // Counter saturation with combined address+write strobes
    loading_ram = 1'b1;
    cyc();
    for (int i = 0; i < 257; i++) begin
      init_set_addr = 1'b1;
      init_set_ram  = 1'b1;
      init_address  = 8'(i);
      init_data     = 8'(i) ^ 8'h5A;
      m_mem[8'(i)]  = 8'(i) ^ 8'h5A;
      cyc();
    end
    init_set_addr = 1'b0;
    init_set_ram  = 1'b0;
    m_mar = 8'h00;
    chk("sat_words", words_loaded, 256);
    chk("sat_mar", mar, 8'h00);
    loading_ram = 1'b0;
    cyc();
    cpu_setmar(8'h33);
    cpu_rd("rd_sat");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_ram.md
# cpu_ram

CPU program/data RAM with its memory address register (MAR), sitting directly downstream of the CPU initialization loader. While the loader holds `loading_ram`, it writes ROM instructions through a dedicated init port. The block then hands the array to the CPU bus, and holds the CPU in wait until the program is loaded. It also tracks how many words were loaded and flags protocol violations on either port.

## Interface
- `ADDR_W`, 8, address / MAR width
- `DATA_W`, 8, word width
- `DEPTH`, 2**ADDR_W, number of words
- `clk`  in  1  system clock, rising-edge
- `reset`  in  1  asynchronous, active-low reset
- `loading_ram`  in  1  loader busy; selects init port
- `init_set_addr`  in  1  load MAR from `init_address`
- `init_set_ram`  in  1  write `init_data` to RAM
- `init_address`  in  ADDR_W  loader address
- `init_data`  in  DATA_W  loader instruction word
- `set_mar`  in  1  CPU: load MAR from `bus_in`
- `set_ram`  in  1  CPU: write `bus_in` to mem[MAR]
- `en_ram`  in  1  CPU: drive mem[MAR] onto bus
- `bus_in`  in  DATA_W  CPU data bus (write side)
- `bus_out`  out  DATA_W  read data; 0 when not enabled
- `bus_oe`  out  1  equals `en_ram` in RUN, else 0
- `mar`  out  ADDR_W  current MAR
- `cpu_run`  out  1  program loaded; CPU may execute
- `words_loaded`  out  ADDR_W+1  init writes since entering LOAD, saturating at DEPTH
- `init_err`  out  1  sticky protocol-error flag

## Operation
- States: IDLE, LOAD, RUN.
  - IDLE→LOAD when `loading_ram`=1.
  - LOAD→RUN when `loading_ram`=0.
  - RUN→LOAD when `loading_ram`=1 (reload).
- Entering LOAD clears `words_loaded` and `cpu_run`.
- LOAD, init port:
  - `init_set_addr` loads MAR.
  - `init_set_ram` writes mem[addr].
  - If both strobes are in the same cycle, the write goes to `init_address`, which bypasses MAR, and MAR takes `init_address`.
  - Each write increments `words_loaded`, saturating at DEPTH.
- LOAD, ordering check: an `init_set_ram` with no `init_set_addr` since the previous init write sets `init_err`. The write still occurs, to the current MAR.
- RUN, CPU port:
  - `set_mar` loads MAR from `bus_in`.
  - `set_ram` writes `bus_in` to mem[MAR].
  - `en_ram` drives `bus_out` combinationally with mem[MAR].
- `set_mar` and `set_ram` asserted together in RUN: write suppressed, MAR not updated, `init_err` set.
- Simultaneous `set_ram` and `en_ram`: `bus_out` shows the pre-write contents; the new value is visible from the next cycle.
- Any CPU strobe in IDLE or LOAD: ignored, `init_err` set.
- Init strobes outside LOAD: ignored silently.
- `init_err` clears only on reset.
- MAR wraps naturally at ADDR_W bits.
- Reset (any time, including mid-load):
  - state=IDLE, `mar`=0, `cpu_run`=0, `words_loaded`=0, `init_err`=0, `bus_oe`=0, `bus_out`=0.
  - RAM contents are NOT reset.

## Timing
- All state, MAR, counter and flag updates occur on the `clk` rising edge.
- Reset acts immediately on assertion; release is synchronized with a 2-flop deassertion synchronizer.
- Write latency: data is readable via `en_ram` on the cycle after the write edge.
- Read latency: zero cycles; `bus_out` is combinational from MAR and `en_ram`.
- `cpu_run` rises on the first edge at which LOAD samples `loading_ram`=0.
- `cpu_run` falls on the first edge at which RUN samples `loading_ram`=1.
- A strobe on the same edge as the LOAD→RUN transition is still processed under LOAD rules.

## Structure
- Package `cpu_pkg` holds:
  - state enum (IDLE, LOAD, RUN);
  - `ADDR_W` and `DATA_W` defaults.
- Sub-module `ram_array`: DEPTH×DATA_W storage, one synchronous write port, one asynchronous read port, no reset.
- FSM, MAR, port mux, counter and error logic live in `cpu_ram`.

## Test plan
- **Reset:** assert `reset`=0 mid-operation → all outputs 0 and state IDLE within the same cycle.
- **Load and read back:**
  - Stimulus: LOAD writes 0x1A, 0x2B, 0x3C to addresses 0..2, each via `init_set_addr` then `init_set_ram`; drop `loading_ram`.
  - Required: `words_loaded`=3; `cpu_run`=1 one edge later; `set_mar` with `bus_in`=1, then `en_ram` → `bus_out`=0x2B, `bus_oe`=1.
- **CPU write:**
  - `set_mar` 0x80, then `set_ram` with 0x55 → next-cycle `en_ram` reads 0x55.
  - Same cycle `set_ram` 0x66 plus `en_ram` → `bus_out`=0x55 that cycle, 0x66 the next.
- **Ordering error:** two `init_set_ram` (0xAA, then 0xBB) without an intervening `init_set_addr` → `init_err`=1, mem[MAR]=0xBB, `words_loaded`=2.
- **Reset mid-load:** reset after 5 of 10 writes → `words_loaded`=0, `cpu_run`=0; previously written words remain readable after a fresh load of 0 words and entry into RUN.
- **Reload and illegal strobes:**
  - Raise `loading_ram` in RUN → `cpu_run`=0 next edge, `words_loaded`=0.
  - `set_ram` during LOAD → `init_err`=1, RAM unchanged.
  - `set_mar`+`set_ram` together in RUN → no write, MAR unchanged, `init_err`=1.
